// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen
// Converts the current scan position into a frame-RAM read address.
// Each pixel resolves to the highest-priority visible sprite, or else the
// background tile map, or else border/none.
// Sprite positions are written into shadow registers at any time. They are
// copied into the active set only on FRAME_START, so a frame is never drawn
// with a half-updated sprite set.
// Fixed two-cycle pipeline:
//   stage 1 - per-sprite hit test and sprite-relative offsets
//   stage 2 - priority pick and address formation
module sprite_addr_gen #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 10,
    parameter int SPRITE_H    = 10,
    parameter int MAP_W       = 256,
    parameter int MAP_H       = 256,
    parameter int ADDR_W      = 17,
    parameter int SPRITE_BASE = 65536,
    parameter int SEL_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              PIX_VALID,
    input  logic              FRAME_START,
    input  logic              SPR_WE,
    input  logic [SEL_W-1:0]  SPR_SEL,
    input  logic [9:0]        SPR_X,
    input  logic [9:0]        SPR_Y,
    input  logic              SPR_EN,
    input  logic              SPR_FLIP,
    output logic [ADDR_W-1:0] mem_address_out,
    output logic              addr_valid,
    output logic [1:0]        layer_out,
    output logic [SEL_W-1:0]  sprite_id_out
);

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(SPRITE_BASE);
    localparam logic [ADDR_W-1:0] SIZE_A  = ADDR_W'(SPRITE_W * SPRITE_H);
    localparam logic [ADDR_W-1:0] SW_A    = ADDR_W'(SPRITE_W);
    localparam logic [ADDR_W-1:0] MAPW_A  = ADDR_W'(MAP_W);
    localparam logic [10:0]       SW11    = 11'(SPRITE_W);
    localparam logic [10:0]       SH11    = 11'(SPRITE_H);
    localparam logic [1:0]        LAYER_NONE = 2'b00;
    localparam logic [1:0]        LAYER_BG   = 2'b01;
    localparam logic [1:0]        LAYER_SPR  = 2'b10;

    // Sprite attribute registers: shadow (CPU side) and active (draw side).
    logic [9:0] sh_x_q    [NUM_SPRITES];
    logic [9:0] sh_y_q    [NUM_SPRITES];
    logic       sh_en_q   [NUM_SPRITES];
    logic       sh_flip_q [NUM_SPRITES];
    logic [9:0] act_x_q   [NUM_SPRITES];
    logic [9:0] act_y_q   [NUM_SPRITES];
    logic       act_en_q  [NUM_SPRITES];
    logic       act_flip_q[NUM_SPRITES];

    // Stage-1 registers and their next-state values.
    logic [NUM_SPRITES-1:0] hit_d, hit_q;
    logic [NUM_SPRITES-1:0] flip_d, flip_q;
    logic [10:0]            dx_d [NUM_SPRITES];
    logic [10:0]            dx_q [NUM_SPRITES];
    logic [10:0]            dy_d [NUM_SPRITES];
    logic [10:0]            dy_q [NUM_SPRITES];
    logic                   bg_d, bg_q;
    logic                   valid1_q;
    logic [9:0]             x1_q, y1_q;

    // Stage-2 registers (module outputs) and their next-state values.
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [1:0]        layer_d, layer_q;
    logic [SEL_W-1:0]  id_d, id_q;
    logic              valid2_q;

    // Stage-2 working signals.
    logic [SEL_W-1:0]  sel_s;
    logic              found_s;
    logic              flip_sel_s;
    logic [10:0]       dx_sel_s;
    logic [10:0]       dy_sel_s;
    logic [10:0]       col_s;
    logic [ADDR_W-1:0] spr_addr_s;
    logic [ADDR_W-1:0] bg_addr_s;

    // Shadow writes and frame-start commit.
    // The commit copies the pre-write shadow contents, because the
    // non-blocking updates of a same-cycle write are not yet visible.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x_q[i]     <= 10'd0;
                sh_y_q[i]     <= 10'd0;
                sh_en_q[i]    <= 1'b0;
                sh_flip_q[i]  <= 1'b0;
                act_x_q[i]    <= 10'd0;
                act_y_q[i]    <= 10'd0;
                act_en_q[i]   <= 1'b0;
                act_flip_q[i] <= 1'b0;
            end
        end else begin
            if (FRAME_START) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    act_x_q[i]    <= sh_x_q[i];
                    act_y_q[i]    <= sh_y_q[i];
                    act_en_q[i]   <= sh_en_q[i];
                    act_flip_q[i] <= sh_flip_q[i];
                end
            end
            if (SPR_WE && (32'(SPR_SEL) < 32'(NUM_SPRITES))) begin
                sh_x_q[SPR_SEL]    <= SPR_X;
                sh_y_q[SPR_SEL]    <= SPR_Y;
                sh_en_q[SPR_SEL]   <= SPR_EN;
                sh_flip_q[SPR_SEL] <= SPR_FLIP;
            end
        end
    end

    // Stage-1 combinational logic: per-sprite hit test and offsets.
    // The test uses 11-bit arithmetic, so a sprite near the right or bottom
    // edge is clipped rather than wrapping back to column or row 0.
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            dx_d[i]   = {1'b0, DrawX} - {1'b0, act_x_q[i]};
            dy_d[i]   = {1'b0, DrawY} - {1'b0, act_y_q[i]};
            flip_d[i] = act_flip_q[i];
            hit_d[i]  = act_en_q[i]
                      & ({1'b0, DrawX} >= {1'b0, act_x_q[i]})
                      & ({1'b0, DrawX} <  ({1'b0, act_x_q[i]} + SW11))
                      & ({1'b0, DrawY} >= {1'b0, act_y_q[i]})
                      & ({1'b0, DrawY} <  ({1'b0, act_y_q[i]} + SH11));
        end
        bg_d = ({22'd0, DrawX} < 32'(MAP_W)) & ({22'd0, DrawY} < 32'(MAP_H));
    end

    // Stage-1 pipeline register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_q    <= '0;
            flip_q   <= '0;
            bg_q     <= 1'b0;
            valid1_q <= 1'b0;
            x1_q     <= 10'd0;
            y1_q     <= 10'd0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                dx_q[i] <= 11'd0;
                dy_q[i] <= 11'd0;
            end
        end else begin
            hit_q    <= hit_d;
            flip_q   <= flip_d;
            bg_q     <= bg_d;
            valid1_q <= PIX_VALID;
            x1_q     <= DrawX;
            y1_q     <= DrawY;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                dx_q[i] <= dx_d[i];
                dy_q[i] <= dy_d[i];
            end
        end
    end

    // Stage-2 combinational logic: priority pick and address formation.
    // Scanning from the highest index down leaves the lowest-index hit
    // selected, which gives sprite 0 the highest priority.
    always_comb begin
        sel_s      = '0;
        found_s    = 1'b0;
        flip_sel_s = 1'b0;
        dx_sel_s   = 11'd0;
        dy_sel_s   = 11'd0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            sel_s      = hit_q[i] ? SEL_W'(i) : sel_s;
            found_s    = hit_q[i] ? 1'b1      : found_s;
            flip_sel_s = hit_q[i] ? flip_q[i] : flip_sel_s;
            dx_sel_s   = hit_q[i] ? dx_q[i]   : dx_sel_s;
            dy_sel_s   = hit_q[i] ? dy_q[i]   : dy_sel_s;
        end
        col_s      = flip_sel_s ? (SW11 - 11'd1 - dx_sel_s) : dx_sel_s;
        spr_addr_s = BASE_A + ADDR_W'(sel_s) * SIZE_A
                   + ADDR_W'(dy_sel_s) * SW_A + ADDR_W'(col_s);
        bg_addr_s  = ADDR_W'(x1_q) + MAPW_A * ADDR_W'(y1_q);
        if (!valid1_q) begin
            addr_d  = '0;
            layer_d = LAYER_NONE;
            id_d    = '0;
        end else if (found_s) begin
            addr_d  = spr_addr_s;
            layer_d = LAYER_SPR;
            id_d    = sel_s;
        end else if (bg_q) begin
            addr_d  = bg_addr_s;
            layer_d = LAYER_BG;
            id_d    = '0;
        end else begin
            addr_d  = '0;
            layer_d = LAYER_NONE;
            id_d    = '0;
        end
    end

    // Stage-2 output register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr_q   <= '0;
            layer_q  <= LAYER_NONE;
            id_q     <= '0;
            valid2_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            layer_q  <= layer_d;
            id_q     <= id_d;
            valid2_q <= valid1_q;
        end
    end

    assign mem_address_out = addr_q;
    assign addr_valid      = valid2_q;
    assign layer_out       = layer_q;
    assign sprite_id_out   = id_q;

endmodule
